pdp8_trace_capture: RTL and testbench
=====================================

// Module: pdp8_trace_capture
// PURPOSE
//  Synthesizable on-chip trace recorder for the PDP-8 core; replaces bench-only $fdisplay tracing.
//  Captures three event channels into one tagged FIFO: instruction retire, memory transaction, branch.
//  Each channel has a 1-deep holding register; a round-robin arbiter drains them into the FIFO.
//  A host (UART dumper or bench) drains the FIFO over a valid/ready port. FIFO mode: stop-on-full or wrap.
// PARAMETERS
//  DEPTH     64  FIFO entries; power of 2, >=4
//  WORD_W    12  PDP-8 word width; all address/data fields use it
//  LOST_W    16  width of saturating lost-event counter
// PORTS
//  clk         in   1          system clock
//  reset       in   1          synchronous, active-high
//  trace_en    in   1          1 = accept new events
//  mode_wrap   in   1          0 = stop-on-full, 1 = overwrite oldest
//  inst_valid  in   1          instruction retired this cycle
//  inst_pc     in   WORD_W     PC after retire
//  inst_ir     in   WORD_W     retired IR
//  inst_ac     in   WORD_W     AC after retire
//  inst_lk     in   1          link after retire
//  mem_valid   in   1          memory transaction finished this cycle
//  mem_addr    in   WORD_W     address
//  mem_data    in   WORD_W     read or write data
//  mem_we      in   1          1 = write (DW), 0 = read
//  mem_ifetch  in   1          read is instruction fetch (IF) vs data read (DR)
//  br_valid    in   1          branch resolved this cycle
//  br_pc       in   WORD_W     branch PC
//  br_target   in   WORD_W     target
//  br_kind     in   2          0 uncond, 1 subroutine, 2 conditional
//  br_taken    in   1          taken flag
//  out_valid   out  1          out_data holds oldest entry
//  out_ready   in   1          consumer accepts entry when out_valid&out_ready
//  out_data    out  2+3*WORD_W+4  {tag[1:0], a, b, c, flags[3:0]}
//  count       out  $clog2(DEPTH)+1  entries in FIFO
//  lost_count  out  LOST_W     dropped + overwritten events, saturating
// BEHAVIOUR
//  Reset: all outputs 0, holding regs empty, pointers 0, arbiter pointer = INST. Reset mid-operation discards everything.
//  Entry encoding: tag 0 INST a=pc b=ir c=ac flags={lk,000}; tag 1 MEM a=addr b=data c=0 flags={we,ifetch,00};
//   tag 2 BR a=pc b=target c=0 flags={taken,kind,0}; tag 3 reserved, never written.
//  Capture: on edge with X_valid & trace_en, holding reg X loads. If X is full and not granted that cycle,
//   new event dropped, lost_count+1. trace_en=0: events ignored, not counted; holding regs still drain.
//  Arbiter: each cycle grants one occupied holding reg, round-robin order INST->MEM->BR starting after last grant.
//   Grant = write into FIFO at that edge; holding reg freed at same edge (may reload same edge).
//  Latency: event at edge N -> FIFO at edge N+1 -> out_valid high after edge N+1 (first-word fall-through).
//  Full, mode_wrap=0: no grant; holding regs retain; new events to full holding regs counted lost.
//  Full, mode_wrap=1: grant writes, oldest entry discarded (rd ptr advances), lost_count+1.
//  Full with pop same cycle: normal push+pop, nothing lost either mode. Empty: out_valid=0, out_data 0.
//  Push+pop same cycle: count unchanged. Pointers wrap modulo DEPTH. lost_count saturates at all-ones.
//  mode_wrap change takes effect next edge; FIFO contents untouched.
// CONFIGURATION
//  TRACE_ADDR_FILTER_EN defined: adds inputs filt_lo, filt_hi (WORD_W); MEM events with addr outside
//   [filt_lo,filt_hi] inclusive and INST events with pc outside it are ignored (not lost). BR unfiltered.
//  Undefined: ports absent, all events eligible.
// TESTING
//  1 Reset: hold reset 3 cycles mid-stream -> out_valid=0, count=0, lost_count=0 next cycle.
//  2 Single inst pc=0201 ir=1177 ac=0005 lk=1 -> after 2 edges out_data={0,0201,1177,0005,1000}, count=1.
//  3 inst+mem+br same cycle, out_ready=1 -> three entries in order tags 0,1,2, lost_count=0.
//  4 mode_wrap=0, DEPTH=64, 70 mem events 1/cycle, out_ready=0 -> count=64, first entry addr intact, lost_count=5
//    (6 beyond FIFO, 1 held in holding reg).
//  5 mode_wrap=1 same stimulus -> count=64, oldest out_data is 7th event, lost_count=6.
//  6 TRACE_ADDR_FILTER_EN, filt 0200-0277, mem addr 0177,0200,0277,0300 -> only 0200,0277 captured.

Source files
------------

// File: rtl/pdp8_trace_if.sv
// Trace event and drain bus for pdp8_trace_capture.
// The master drives events and accepts drained entries; the slave is the capture block.
interface pdp8_trace_if #(
    parameter int unsigned WORD_W = 12
);
    logic              inst_valid;
    logic [WORD_W-1:0] inst_pc;
    logic [WORD_W-1:0] inst_ir;
    logic [WORD_W-1:0] inst_ac;
    logic              inst_lk;

    logic              mem_valid;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_data;
    logic              mem_we;
    logic              mem_ifetch;

    logic              br_valid;
    logic [WORD_W-1:0] br_pc;
    logic [WORD_W-1:0] br_target;
    logic [1:0]        br_kind;
    logic              br_taken;

    logic                    out_valid;
    logic                    out_ready;
    logic [2+3*WORD_W+4-1:0] out_data;

    modport master (
        output inst_valid, inst_pc, inst_ir, inst_ac, inst_lk,
        output mem_valid, mem_addr, mem_data, mem_we, mem_ifetch,
        output br_valid, br_pc, br_target, br_kind, br_taken,
        output out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  inst_valid, inst_pc, inst_ir, inst_ac, inst_lk,
        input  mem_valid, mem_addr, mem_data, mem_we, mem_ifetch,
        input  br_valid, br_pc, br_target, br_kind, br_taken,
        input  out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/pdp8_trace_capture.sv
// PDP-8 trace recorder: three event channels, 1-deep holding regs, round-robin into a tagged FIFO.
// Optional TRACE_ADDR_FILTER_EN adds filt_lo/filt_hi to drop INST/MEM events outside the window.
module pdp8_trace_capture #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned WORD_W = 12,
    parameter int unsigned LOST_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_en,
    input  logic                     mode_wrap,
`ifdef TRACE_ADDR_FILTER_EN
    input  logic [WORD_W-1:0]        filt_lo,
    input  logic [WORD_W-1:0]        filt_hi,
`endif
    pdp8_trace_if.slave              bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic [LOST_W-1:0]        lost_count
);
    localparam int unsigned ENTRY_W = 2 + 3 * WORD_W + 4;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [1:0] CH_INST = 2'd0;
    localparam logic [1:0] CH_MEM  = 2'd1;
    localparam logic [1:0] CH_BR   = 2'd2;

    logic [2:0]         hold_v_q, hold_v_d;
    logic [ENTRY_W-1:0] hold_q [3];
    logic [ENTRY_W-1:0] hold_d [3];
    logic [1:0]         rr_q, rr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [LOST_W-1:0]  lost_q, lost_d;
    logic [ENTRY_W-1:0] fifo_mem [DEPTH];

    logic [2:0]         ev_valid;
    logic [ENTRY_W-1:0] ev_entry [3];
    logic               inst_ok, mem_ok;
    logic               full, pop, push_ok, push, overwrite;
    logic [5:0]         prio;
    logic [1:0]         gnt_ch;
    logic [2:0]         gnt_oh;
    logic [2:0]         lost_inc;
    logic [LOST_W:0]    lost_sum;

`ifdef TRACE_ADDR_FILTER_EN
    assign inst_ok = (bus.inst_pc >= filt_lo) && (bus.inst_pc <= filt_hi);
    assign mem_ok  = (bus.mem_addr >= filt_lo) && (bus.mem_addr <= filt_hi);
`else
    assign inst_ok = 1'b1;
    assign mem_ok  = 1'b1;
`endif

    always_comb begin
        ev_valid[0] = bus.inst_valid & trace_en & inst_ok;
        ev_valid[1] = bus.mem_valid & trace_en & mem_ok;
        ev_valid[2] = bus.br_valid & trace_en;
        ev_entry[0] = {2'd0, bus.inst_pc, bus.inst_ir, bus.inst_ac, bus.inst_lk, 3'b000};
        ev_entry[1] = {2'd1, bus.mem_addr, bus.mem_data, {WORD_W{1'b0}},
                       bus.mem_we, bus.mem_ifetch, 2'b00};
        ev_entry[2] = {2'd2, bus.br_pc, bus.br_target, {WORD_W{1'b0}},
                       bus.br_taken, bus.br_kind, 1'b0};
    end

    assign full    = (count_q == FULL_CNT);
    assign pop     = (count_q != '0) & bus.out_ready;
    assign push_ok = ~full | pop | mode_wrap;

    // prio[1:0] is the highest-priority channel, starting at the one after the last grant.
    always_comb begin
        case (rr_q)
            CH_INST: prio = {CH_BR, CH_MEM, CH_INST};
            CH_MEM:  prio = {CH_INST, CH_BR, CH_MEM};
            default: prio = {CH_MEM, CH_INST, CH_BR};
        endcase
        gnt_ch = prio[1:0];
        if (hold_v_q[prio[1:0]])      gnt_ch = prio[1:0];
        else if (hold_v_q[prio[3:2]]) gnt_ch = prio[3:2];
        else                          gnt_ch = prio[5:4];
        push      = push_ok & (|hold_v_q);
        gnt_oh    = push ? (3'b001 << gnt_ch) : 3'b000;
        overwrite = push & full & ~pop;
    end

    always_comb begin
        hold_v_d = hold_v_q;
        hold_d   = hold_q;
        lost_inc = overwrite ? 3'd1 : 3'd0;
        for (int i = 0; i < 3; i++) begin
            if (gnt_oh[i]) hold_v_d[i] = 1'b0;
            if (ev_valid[i]) begin
                if (!hold_v_q[i] || gnt_oh[i]) begin
                    hold_v_d[i] = 1'b1;
                    hold_d[i]   = ev_entry[i];
                end else begin
                    lost_inc = lost_inc + 3'd1;
                end
            end
        end
        rr_d     = push ? ((gnt_ch == CH_BR) ? CH_INST : gnt_ch + 2'd1) : rr_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop | overwrite);
        count_d  = count_q;
        if (push && !pop && !full) count_d = count_q + (PTR_W + 1)'(1);
        else if (pop && !push)     count_d = count_q - (PTR_W + 1)'(1);
        lost_sum = {1'b0, lost_q} + {{(LOST_W - 2){1'b0}}, lost_inc};
        lost_d   = lost_sum[LOST_W] ? {LOST_W{1'b1}} : lost_sum[LOST_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_v_q <= '0;
            hold_q   <= '{default: '0};
            rr_q     <= CH_INST;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            lost_q   <= '0;
        end else begin
            hold_v_q <= hold_v_d;
            hold_q   <= hold_d;
            rr_q     <= rr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            lost_q   <= lost_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) fifo_mem[wr_ptr_q] <= hold_q[gnt_ch];
    end

    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = bus.out_valid ? fifo_mem[rd_ptr_q] : '0;
    assign count         = count_q;
    assign lost_count    = lost_q;
endmodule

// File: tb/tb_pdp8_trace_capture.sv
// Scoreboard bench for pdp8_trace_capture: queue-level reference model plus directed scenarios.
module tb_pdp8_trace_capture;
    localparam int unsigned DEPTH   = 64;
    localparam int unsigned WORD_W  = 12;
    localparam int unsigned LOST_W  = 16;
    localparam int unsigned ENTRY_W = 2 + 3 * WORD_W + 4;

    logic clk = 1'b0;
    logic reset;
    logic trace_en;
    logic mode_wrap;
    logic [$clog2(DEPTH):0] count;
    logic [LOST_W-1:0]      lost_count;
`ifdef TRACE_ADDR_FILTER_EN
    logic [WORD_W-1:0] filt_lo;
    logic [WORD_W-1:0] filt_hi;
`endif

    pdp8_trace_if #(.WORD_W(WORD_W)) bus ();

    pdp8_trace_capture #(.DEPTH(DEPTH), .WORD_W(WORD_W), .LOST_W(LOST_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .trace_en   (trace_en),
        .mode_wrap  (mode_wrap),
`ifdef TRACE_ADDR_FILTER_EN
        .filt_lo    (filt_lo),
        .filt_hi    (filt_hi),
`endif
        .bus        (bus),
        .count      (count),
        .lost_count (lost_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] pack(input logic [1:0] tag, input logic [11:0] a,
                                                 input logic [11:0] b, input logic [11:0] c,
                                                 input logic [3:0] f);
        return {tag, a, b, c, f};
    endfunction

    function automatic bit in_window(input logic [WORD_W-1:0] addr);
`ifdef TRACE_ADDR_FILTER_EN
        return (addr >= filt_lo) && (addr <= filt_hi);
`else
        return addr == addr;
`endif
    endfunction

    // Reference model: expected FIFO as a queue, one optional slot per channel.
    logic [ENTRY_W-1:0] m_q[$];
    logic [ENTRY_W-1:0] m_slot [3];
    bit                 m_occ [3];
    logic [ENTRY_W-1:0] m_ev [3];
    bit                 m_evv [3];
    int                 m_rr;
    int                 m_lost;
    bit                 started = 1'b0;

    always @(posedge clk) begin
        int g;
        int inc;
        bit can_write;
        if (reset) begin
            m_q.delete();
            foreach (m_occ[i]) m_occ[i] = 1'b0;
            m_rr    = 0;
            m_lost  = 0;
            started = 1'b1;
        end else if (started) begin
            m_evv[0] = bus.inst_valid && trace_en && in_window(bus.inst_pc);
            m_evv[1] = bus.mem_valid && trace_en && in_window(bus.mem_addr);
            m_evv[2] = bus.br_valid && trace_en;
            m_ev[0] = pack(2'd0, bus.inst_pc, bus.inst_ir, bus.inst_ac, {bus.inst_lk, 3'b000});
            m_ev[1] = pack(2'd1, bus.mem_addr, bus.mem_data, 12'd0,
                           {bus.mem_we, bus.mem_ifetch, 2'b00});
            m_ev[2] = pack(2'd2, bus.br_pc, bus.br_target, 12'd0,
                           {bus.br_taken, bus.br_kind, 1'b0});
            inc = 0;
            can_write = (m_q.size() < DEPTH) || bus.out_ready || mode_wrap;
            if (m_q.size() > 0 && bus.out_ready) void'(m_q.pop_front());
            g = -1;
            if (can_write) begin
                for (int k = 0; k < 3; k++) begin
                    if (g < 0 && m_occ[(m_rr + k) % 3]) g = (m_rr + k) % 3;
                end
            end
            if (g >= 0) begin
                if (m_q.size() == DEPTH) begin
                    void'(m_q.pop_front());
                    inc++;
                end
                m_q.push_back(m_slot[g]);
                m_occ[g] = 1'b0;
                m_rr = (g + 1) % 3;
            end
            for (int c = 0; c < 3; c++) begin
                if (m_evv[c]) begin
                    if (!m_occ[c]) begin
                        m_occ[c]  = 1'b1;
                        m_slot[c] = m_ev[c];
                    end else begin
                        inc++;
                    end
                end
            end
            m_lost = m_lost + inc;
            if (m_lost > (1 << LOST_W) - 1) m_lost = (1 << LOST_W) - 1;
        end
    end

    // Monitor: compares the head entry whenever the DUT presents one, plus status outputs.
    always @(negedge clk) begin
        if (started) begin
            check("count", 64'(count), 64'(m_q.size()));
            check("lost_count", 64'(lost_count), 64'(m_lost));
            check("out_valid", 64'(bus.out_valid), 64'(m_q.size() != 0));
            if (bus.out_valid && m_q.size() != 0) check("out_data", 64'(bus.out_data), 64'(m_q[0]));
            else if (m_q.size() == 0) check("out_data_empty", 64'(bus.out_data), 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.inst_valid = 1'b0;
        bus.mem_valid  = 1'b0;
        bus.br_valid   = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    task automatic randomize_fields();
        bus.inst_pc    = 12'($urandom);
        bus.inst_ir    = 12'($urandom);
        bus.inst_ac    = 12'($urandom);
        bus.inst_lk    = 1'($urandom);
        bus.mem_addr   = 12'($urandom);
        bus.mem_data   = 12'($urandom);
        bus.mem_we     = 1'($urandom);
        bus.mem_ifetch = 1'($urandom);
        bus.br_pc      = 12'($urandom);
        bus.br_target  = 12'($urandom);
        bus.br_kind    = 2'($urandom_range(0, 2));
        bus.br_taken   = 1'($urandom);
    endtask

    task automatic mem_burst(input bit wrap);
        do_reset(2);
        mode_wrap     = wrap;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 70; i++) begin
            bus.mem_valid = 1'b1;
            bus.mem_addr  = 12'(i);
            bus.mem_data  = 12'($urandom);
            tick();
        end
        idle_inputs();
        repeat (4) tick();
    endtask

    int ready_pct [6] = '{10, 90, 0, 50, 30, 100};

    initial begin
        reset         = 1'b1;
        trace_en      = 1'b1;
        mode_wrap     = 1'b0;
        bus.out_ready = 1'b0;
`ifdef TRACE_ADDR_FILTER_EN
        filt_lo = 12'o0000;
        filt_hi = 12'o7777;
`endif
        idle_inputs();
        randomize_fields();
        do_reset(3);
        tick();

        // Single instruction event.
        bus.inst_valid = 1'b1;
        bus.inst_pc    = 12'o0201;
        bus.inst_ir    = 12'o1177;
        bus.inst_ac    = 12'o0005;
        bus.inst_lk    = 1'b1;
        tick();
        idle_inputs();
        tick();
        check("single_inst_data", 64'(bus.out_data),
              64'({2'd0, 12'o0201, 12'o1177, 12'o0005, 4'b1000}));
        check("single_inst_count", 64'(count), 64'd1);
        bus.out_ready = 1'b1;
        repeat (2) tick();

        // All three channels in one cycle drain in INST, MEM, BR order.
        do_reset(1);
        randomize_fields();
        bus.inst_valid = 1'b1;
        bus.mem_valid  = 1'b1;
        bus.br_valid   = 1'b1;
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("triple_tag", 64'(bus.out_data[ENTRY_W-1 -: 2]), 64'(k));
        end
        check("triple_lost", 64'(lost_count), 64'd0);
        repeat (2) tick();

        // Stop-on-full burst.
        mem_burst(1'b0);
        check("stop_count", 64'(count), 64'(DEPTH));
        check("stop_first_addr", 64'(bus.out_data[ENTRY_W-3 -: WORD_W]), 64'd0);
        check("stop_lost", 64'(lost_count), 64'd5);
        bus.out_ready = 1'b1;
        repeat (70) tick();

        // Wrap burst.
        mem_burst(1'b1);
        check("wrap_count", 64'(count), 64'(DEPTH));
        check("wrap_first_addr", 64'(bus.out_data[ENTRY_W-3 -: WORD_W]), 64'd6);
        check("wrap_lost", 64'(lost_count), 64'd6);
        bus.out_ready = 1'b1;
        repeat (70) tick();

`ifdef TRACE_ADDR_FILTER_EN
        do_reset(1);
        filt_lo       = 12'o0200;
        filt_hi       = 12'o0277;
        bus.out_ready = 1'b0;
        foreach (ready_pct[i]) begin
            bus.mem_valid = (i < 4);
            bus.mem_addr  = (i == 0) ? 12'o0177 : (i == 1) ? 12'o0200 :
                            (i == 2) ? 12'o0277 : 12'o0300;
            tick();
        end
        idle_inputs();
        repeat (3) tick();
        check("filter_count", 64'(count), 64'd2);
        check("filter_first", 64'(bus.out_data[ENTRY_W-3 -: WORD_W]), 64'o0200);
        filt_lo = 12'o0000;
        filt_hi = 12'o7777;
        bus.out_ready = 1'b1;
        repeat (4) tick();
`endif

        // Randomized traffic with varying drain rates and modes.
        do_reset(1);
        for (int ph = 0; ph < 6; ph++) begin
            mode_wrap = ph[0];
            for (int c = 0; c < 300; c++) begin
                randomize_fields();
                bus.inst_valid = ($urandom_range(0, 99) < 60);
                bus.mem_valid  = ($urandom_range(0, 99) < 60);
                bus.br_valid   = ($urandom_range(0, 99) < 30);
                trace_en       = ($urandom_range(0, 7) != 0);
                bus.out_ready  = ($urandom_range(0, 99) < ready_pct[ph]);
                if (c == 150 && ph == 3) mode_wrap = ~mode_wrap;
                tick();
            end
        end

        // Reset held mid-stream discards everything.
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        idle_inputs();
        check("mid_reset_valid", 64'(bus.out_valid), 64'd0);
        check("mid_reset_count", 64'(count), 64'd0);
        check("mid_reset_lost", 64'(lost_count), 64'd0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
